// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory stall controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Counts ACCESS cycles without an ack; expired_o flags the TIMEOUT-th such cycle.
module dmem_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Combinational compare lets the FSM leave ACCESS in the TIMEOUT-th cycle itself.
  assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_stall_ctrl.sv
// MEM-stage data-memory controller: latches a request, handshakes with slow memory, stalls the pipeline.
// Optional access timeout enabled by defining DMEM_TIMEOUT_EN.
module dmem_stall_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_read_i,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              err_o
);

  state_e             state_q, state_d;
  op_e                op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               latch;
  logic               expired;

`ifdef DMEM_TIMEOUT_EN
  dmem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q != ACCESS),
    .enable_i  ((state_q == ACCESS) && !mem_ack_i),
    .expired_o (expired)
  );
`else
  // TIMEOUT only matters when the counter is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expired        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_read_i || req_write_i) begin
          latch   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // A late ack beats an expiring counter in the same cycle.
        if (mem_ack_i) begin
          if (op_q == OP_READ) rdata_d = mem_rdata_i;
          state_d = DONE;
        end else if (expired) begin
          if (op_q == OP_READ) rdata_d = '1;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (latch) begin
        op_q    <= req_write_i ? OP_WRITE : OP_READ;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end

  // Gated by reset so a request held across reset cannot keep the pipeline frozen.
  assign stall_o      = ~rst_i & (((state_q == IDLE) & (req_read_i | req_write_i))
                                  | (state_q == ACCESS));
  assign mem_enable_o = (state_q == ACCESS);
  assign mem_write_o  = (state_q == ACCESS) & (op_q == OP_WRITE);
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign rdata_o      = rdata_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Directed scoreboard bench for dmem_stall_ctrl; timeout cases run when DMEM_TIMEOUT_EN is defined.
module tb_dmem_stall_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_read_i, req_write_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o, mem_enable_o, mem_write_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] rdata_model = 32'h0;
  logic [31:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  dmem_stall_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_read_i   (req_read_i),
    .req_write_i  (req_write_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .rdata_o      (rdata_o),
    .stall_o      (stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i),
    .err_o        (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled mid-low-phase.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // One access: ack in ACCESS cycle ack_at; optionally keep requests asserted through DONE.
  task automatic do_access(input string name, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] memdata, input int ack_at, input bit hold);
    int stall_cnt = 0;
    int en_cnt = 0;
    logic [31:0] got;
    req_read_i  = rd;
    req_write_i = wr;
    addr_i      = addr;
    wdata_i     = wdata;
    if (!wr) rdata_model = memdata;
    exp_q.push_back(rdata_model);
    #1;
    chk({name, " idle stall"}, {31'd0, stall_o}, 32'd1);
    chk({name, " idle enable"}, {31'd0, mem_enable_o}, 32'd0);
    if (stall_o) stall_cnt++;
    for (int k = 1; k <= ack_at; k++) begin
      tick();
      // The pipeline holds the request but its address/data may drift; latched values must not.
      addr_i      = $urandom;
      wdata_i     = $urandom;
      mem_ack_i   = (k == ack_at);
      mem_rdata_i = (k == ack_at) ? memdata : $urandom;
      #1;
      if (stall_o) stall_cnt++;
      if (mem_enable_o) en_cnt++;
      chk({name, " acc write"}, {31'd0, mem_write_o}, {31'd0, wr});
      chk({name, " acc addr"}, mem_addr_o, addr);
      if (wr) chk({name, " acc wdata"}, mem_wdata_o, wdata);
    end
    tick();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'hA5A5_A5A5;
    if (!hold) begin
      req_read_i  = 1'b0;
      req_write_i = 1'b0;
    end
    #1;
    got = exp_q.pop_front();
    chk({name, " done stall"}, {31'd0, stall_o}, 32'd0);
    chk({name, " done enable"}, {31'd0, mem_enable_o}, 32'd0);
    chk({name, " done rdata"}, rdata_o, got);
    chk({name, " done err"}, {31'd0, err_o}, 32'd0);
    chk({name, " stall cycles"}, stall_cnt, ack_at + 1);
    chk({name, " enable cycles"}, en_cnt, ack_at);
    $display("txn %s rd=%0b wr=%0b addr=%h ack_at=%0d rdata=%h", name, rd, wr, addr, ack_at, rdata_o);
    tick();
  endtask

  initial begin
    rst_i       = 1'b1;
    req_read_i  = 1'b0;
    req_write_i = 1'b0;
    addr_i      = '0;
    wdata_i     = '0;
    mem_rdata_i = '0;
    mem_ack_i   = 1'b0;
    tick();
    chk("reset stall", {31'd0, stall_o}, 32'd0);
    chk("reset enable", {31'd0, mem_enable_o}, 32'd0);
    chk("reset rdata", rdata_o, 32'd0);
    chk("reset err", {31'd0, err_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    do_access("rd_ack1", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1, 1'b0);
    do_access("wr_ack5", 1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0BAD_0BAD, 5, 1'b0);

    // Back-to-back: requests held through DONE, then the next one presented in IDLE.
    do_access("b2b_rd", 1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 2, 1'b1);
    do_access("b2b_wr", 1'b0, 1'b1, 32'h0000_0204, 32'h5555_AAAA, 32'h0, 3, 1'b0);
    chk("b2b idle stall", {31'd0, stall_o}, 32'd0);

    // Spurious ack in IDLE must be ignored.
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h7777_7777;
    #1;
    chk("spur stall", {31'd0, stall_o}, 32'd0);
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("spur enable", {31'd0, mem_enable_o}, 32'd0);
    chk("spur rdata", rdata_o, rdata_model);
    $display("txn spurious_ack rdata=%h", rdata_o);
    tick();

    do_access("both_req", 1'b1, 1'b1, 32'h0000_0300, 32'h0F0F_0F0F, 32'h0, 1, 1'b0);
    do_access("rd_long", 1'b1, 1'b0, 32'h0000_0404, 32'h0, 32'h1357_9BDF, 4, 1'b0);

    // Reset while ACCESS, request still held.
    req_read_i = 1'b1;
    addr_i     = 32'h0000_0500;
    tick();
    #1;
    chk("rst_pre enable", {31'd0, mem_enable_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rst_mid stall", {31'd0, stall_o}, 32'd0);
    chk("rst_mid enable", {31'd0, mem_enable_o}, 32'd0);
    chk("rst_mid err", {31'd0, err_o}, 32'd0);
    rdata_model = 32'h0;
    tick();
    req_read_i = 1'b0;
    rst_i      = 1'b0;
    tick();
    chk("rst_post stall", {31'd0, stall_o}, 32'd0);
    chk("rst_post enable", {31'd0, mem_enable_o}, 32'd0);
    chk("rst_post rdata", rdata_o, 32'd0);
    $display("txn reset_mid_access rdata=%h", rdata_o);

`ifdef DMEM_TIMEOUT_EN
    // No ack: eight ACCESS cycles then DONE with error and all-ones data.
    req_read_i = 1'b1;
    addr_i     = 32'h0000_0600;
    tick();
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk("to enable", {31'd0, mem_enable_o}, 32'd1);
      tick();
    end
    req_read_i = 1'b0;
    #1;
    chk("to done enable", {31'd0, mem_enable_o}, 32'd0);
    chk("to done err", {31'd0, err_o}, 32'd1);
    chk("to done rdata", rdata_o, 32'hFFFF_FFFF);
    $display("txn timeout err=%0b rdata=%h", err_o, rdata_o);
    rdata_model = 32'hFFFF_FFFF;
    tick();
    chk("to err clear", {31'd0, err_o}, 32'd0);
    do_access("to_ack8", 1'b1, 1'b0, 32'h0000_0604, 32'h0, 32'h2468_ACE0, 8, 1'b0);
`else
    do_access("rd_ack20", 1'b1, 1'b0, 32'h0000_0700, 32'h0, 32'h8642_0FED, 20, 1'b0);
`endif

    chk("scoreboard empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
